// File: rtl/load_unit.sv
// Load unit: fetches the containing word over req/ack, extracts and extends the addressed
// byte/half/word, and returns it over valid/ready. Misaligned accesses and memory timeouts error.
module load_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_error
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           r_state, w_state_next;
  logic [1:0]       r_lane, w_lane_next;
  logic [1:0]       r_size, w_size_next;
  logic             r_signed, w_signed_next;
  logic [WIDTH-1:0] r_addr, w_addr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic             r_error, w_error_next;

  logic             w_illegal;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_ext;

  assign req_ready  = (r_state == StIdle);
  assign mem_req    = (r_state == StWait);
  assign resp_valid = (r_state == StResp);
  assign mem_addr   = r_addr;
  assign resp_data  = r_data;
  assign resp_error = r_error;

  always_comb begin
    w_illegal = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Lane selection uses the latched request attributes, so only mem_rdata is live at ack time.
  always_comb begin
    w_byte = mem_rdata[7:0];
    unique case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_ext = {{(WIDTH-8){r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{(WIDTH-16){r_signed & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_lane_next   = r_lane;
    w_size_next   = r_size;
    w_signed_next = r_signed;
    w_addr_next   = r_addr;
    w_cnt_next    = r_cnt;
    w_data_next   = r_data;
    w_error_next  = r_error;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_lane_next   = req_addr[1:0];
          w_size_next   = req_size;
          w_signed_next = req_signed;
          w_cnt_next    = '0;
          if (w_illegal) begin
            w_state_next = StResp;
            w_data_next  = '0;
            w_error_next = 1'b1;
          end else begin
            w_state_next = StWait;
            w_addr_next  = {req_addr[WIDTH-1:2], 2'b00};
          end
        end
      end
      StWait: begin
        // Ack on the final timeout cycle takes priority over the timeout.
        if (mem_ack) begin
          w_state_next = StResp;
          w_data_next  = w_ext;
          w_error_next = 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_next = StResp;
          w_data_next  = '0;
          w_error_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= StIdle;
      r_lane   <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_lane   <= w_lane_next;
      r_size   <= w_size_next;
      r_signed <= w_signed_next;
      r_addr   <= w_addr_next;
      r_cnt    <= w_cnt_next;
      r_data   <= w_data_next;
      r_error  <= w_error_next;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: extraction, misalignment, timeout, backpressure and clear.
module tb_load_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  load_unit #(
    .WIDTH  (32),
    .TIMEOUT(16),
    .CNT_W  (5)
  ) u_dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_signed(req_signed),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_error(resp_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, ack on WAIT cycle ack_cycle (0 = never), hold off resp_ready for
  // hold cycles, then complete the handshake.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] rdata, input int ack_cycle,
                          input int exp_cycles, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data, input logic exp_err, input int hold);
    int n;
    @(negedge clock);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    @(negedge clock);
    req_valid = 1'b0;
    if (exp_cycles > 0) check({tag, ".mem_addr"}, mem_addr, exp_addr);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!mem_req) break;
      n++;
      if (c == ack_cycle) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clock);
      mem_ack = 1'b0;
    end
    check({tag, ".req_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".resp_data"}, resp_data, exp_data);
    check({tag, ".resp_error"}, {31'd0, resp_error}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, ".hold_data"}, resp_data, exp_data);
      check({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    clear      = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0100;
    req_size   = 2'b10;
    req_signed = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    resp_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear     = 1'b0;
    req_valid = 1'b0;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.resp_error", {31'd0, resp_error}, 32'd0);

    run_load("sbyte", 32'h103, 2'b00, 1'b1, 32'h80FF_1234, 3, 3, 32'h100, 32'hFFFF_FF80, 1'b0, 0);
    run_load("ubyte1", 32'h101, 2'b00, 1'b0, 32'h80FF_1234, 1, 1, 32'h100, 32'h0000_0012, 1'b0, 0);
    run_load("uhalf", 32'h22, 2'b01, 1'b0, 32'hBEEF_0000, 2, 2, 32'h20, 32'h0000_BEEF, 1'b0, 0);
    run_load("shalf", 32'h22, 2'b01, 1'b1, 32'hBEEF_0000, 1, 1, 32'h20, 32'hFFFF_BEEF, 1'b0, 0);
    run_load("word", 32'h20, 2'b10, 1'b1, 32'hBEEF_0000, 2, 2, 32'h20, 32'hBEEF_0000, 1'b0, 0);
    run_load("misw", 32'h41, 2'b10, 1'b0, 32'h1111_1111, 0, 0, 32'h0, 32'h0, 1'b1, 0);
    run_load("size3", 32'h40, 2'b11, 1'b0, 32'h1111_1111, 0, 0, 32'h0, 32'h0, 1'b1, 0);
    run_load("tmo", 32'h200, 2'b10, 1'b0, 32'h5555_5555, 0, 16, 32'h200, 32'h0, 1'b1, 5);
    run_load("acklast", 32'h304, 2'b10, 1'b0, 32'hCAFE_F00D, 16, 16, 32'h304, 32'hCAFE_F00D,
             1'b0, 0);

    // Clear four cycles into WAIT, then a stray ack must be ignored.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 32'h400;
    req_size  = 2'b10;
    @(negedge clock);
    req_valid = 1'b0;
    check("clr.mem_req_on", {31'd0, mem_req}, 32'd1);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr.mem_req_off", {31'd0, mem_req}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("clr.no_resp", {31'd0, resp_valid}, 32'd0);
      check("clr.no_req", {31'd0, mem_req}, 32'd0);
      @(negedge clock);
    end
    run_load("post", 32'h102, 2'b00, 1'b0, 32'h00A5_0000, 2, 2, 32'h100, 32'h0000_00A5, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
